// File: rtl/expr_eval_ctrl_pkg.sv
// Shared constants for the expression evaluation controller.
// Holds the ASCII codes the character classifier recognises and the
// two-bit FSM state encoding used by the top-level controller.
package expr_eval_ctrl_pkg;

    localparam int unsigned CH_W    = 8;
    localparam int unsigned DVAL_W  = 4;
    localparam int unsigned STATE_W = 2;

    // ASCII codes of the recognised characters
    localparam logic [CH_W-1:0] CH_0    = 8'h30;
    localparam logic [CH_W-1:0] CH_9    = 8'h39;
    localparam logic [CH_W-1:0] CH_PLUS = 8'h2B;
    localparam logic [CH_W-1:0] CH_MUL  = 8'h2A;
    localparam logic [CH_W-1:0] CH_EQ   = 8'h3D;

    // FSM state encoding
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;  // expecting first digit
    localparam logic [STATE_W-1:0] S_OPR  = 2'd1;  // after digit, expecting operator or '='
    localparam logic [STATE_W-1:0] S_DIG  = 2'd2;  // after operator, expecting digit
    localparam logic [STATE_W-1:0] S_ERR  = 2'd3;  // syntax error, absorbing until '='

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier.
// Ports:
//   in       - ASCII character
//   is_digit - in is '0'..'9'
//   is_plus  - in is '+'
//   is_mul   - in is '*'
//   is_eq    - in is '='
//   dval     - numeric digit value (0 when in is not a digit)
module expr_char_class
    import expr_eval_ctrl_pkg::*;
(
    input  logic [CH_W-1:0]   in,
    output logic              is_digit,
    output logic              is_plus,
    output logic              is_mul,
    output logic              is_eq,
    output logic [DVAL_W-1:0] dval
);

    logic [CH_W-1:0] offset;

    assign offset   = in - CH_0;
    assign is_digit = (in >= CH_0) && (in <= CH_9);
    assign is_plus  = (in == CH_PLUS);
    assign is_mul   = (in == CH_MUL);
    assign is_eq    = (in == CH_EQ);
    // Digits span 0..9, so the low nibble of the offset is the full value
    assign dval     = is_digit ? DVAL_W'(offset) : '0;

endmodule

// File: rtl/expr_eval_ctrl.sv
// Sequencing controller for single-digit '+'/'*' expressions terminated by '='.
// A sum/product accumulator pair gives '*' precedence over '+': prod holds
// the running product term, sum holds the total of completed terms.
// Ports:
//   clk      - clock
//   clr      - synchronous active-high reset
//   in_valid - in carries a character this cycle
//   in       - ASCII character
//   done     - one-cycle pulse, one cycle after '=' is consumed
//   ok       - 1 = well-formed expression, 0 = syntax error (valid with done)
//   result   - evaluated value on success, 0 on error; held between reports
module expr_eval_ctrl
    import expr_eval_ctrl_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [CH_W-1:0] in,
    output logic            done,
    output logic            ok,
    output logic [W-1:0]    result
);

    logic              is_digit;
    logic              is_plus;
    logic              is_mul;
    logic              is_eq;
    logic [DVAL_W-1:0] dval;

    logic [STATE_W-1:0] state, state_nxt;
    logic [W-1:0]       sum, sum_nxt;
    logic [W-1:0]       prod, prod_nxt;
    logic               pend_mul, pend_mul_nxt;
    logic               done_nxt, ok_nxt;
    logic [W-1:0]       result_nxt;
    logic               rpt, rpt_ok;
    logic [W-1:0]       dval_w;

    expr_char_class u_class (
        .in       (in),
        .is_digit (is_digit),
        .is_plus  (is_plus),
        .is_mul   (is_mul),
        .is_eq    (is_eq),
        .dval     (dval)
    );

    assign dval_w = W'(dval);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_IDLE;
            sum      <= '0;
            prod     <= '0;
            pend_mul <= 1'b0;
            done     <= 1'b0;
            ok       <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_nxt;
            sum      <= sum_nxt;
            prod     <= prod_nxt;
            pend_mul <= pend_mul_nxt;
            done     <= done_nxt;
            ok       <= ok_nxt;
            result   <= result_nxt;
        end
    end

    // Next-state, accumulator update and report generation
    always_comb begin
        state_nxt    = state;
        sum_nxt      = sum;
        prod_nxt     = prod;
        pend_mul_nxt = pend_mul;
        done_nxt     = 1'b0;
        ok_nxt       = ok;
        result_nxt   = result;
        rpt          = 1'b0;
        rpt_ok       = 1'b0;

        if (in_valid) begin
            case (state)
                S_IDLE: begin
                    if (is_digit) begin
                        sum_nxt   = '0;
                        prod_nxt  = dval_w;
                        state_nxt = S_OPR;
                    end else if (is_eq) begin
                        rpt       = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                S_OPR: begin
                    if (is_plus) begin
                        // Close the current product term into the sum
                        sum_nxt      = sum + prod;
                        pend_mul_nxt = 1'b0;
                        state_nxt    = S_DIG;
                    end else if (is_mul) begin
                        pend_mul_nxt = 1'b1;
                        state_nxt    = S_DIG;
                    end else if (is_eq) begin
                        rpt       = 1'b1;
                        rpt_ok    = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        // A second digit here would be a multi-digit operand
                        state_nxt = S_ERR;
                    end
                end
                S_DIG: begin
                    if (is_digit) begin
                        prod_nxt  = pend_mul ? prod * dval_w : dval_w;
                        state_nxt = S_OPR;
                    end else if (is_eq) begin
                        rpt       = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                default: begin
                    if (is_eq) begin
                        rpt       = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            endcase
        end

        if (rpt) begin
            done_nxt   = 1'b1;
            ok_nxt     = rpt_ok;
            result_nxt = rpt_ok ? sum + prod : '0;
        end
    end

endmodule
